// File: rtl/data_delay_meas.sv
// Measures the delay between a reference stream and a delayed copy of it.
// It searches the reference history taps for the lowest one that keeps matching, then tracks the lock.
module data_delay_meas #(
    parameter int WIDTH     = 4,
    parameter int MAX_DELAY = 7,
    parameter int MATCH_LEN = 8,
    parameter int LOSS_LEN  = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [WIDTH-1:0]               ref_in,
    input  logic [WIDTH-1:0]               dly_in,
    output logic [$clog2(MAX_DELAY+1)-1:0] delay,
    output logic                           valid,
    output logic                           busy,
    output logic                           fail
);

    localparam int DW = $clog2(MAX_DELAY + 1);
    localparam int CW = $clog2(MATCH_LEN + 1);
    localparam int LW = $clog2(LOSS_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  sreg [1:MAX_DELAY];
    logic [WIDTH-1:0]  hist [0:MAX_DELAY];
    logic [DW-1:0]     fill;
    logic [CW-1:0]     cnt  [0:MAX_DELAY];
    logic [MAX_DELAY:0] hit, winner;
    logic              any_win;
    logic [DW-1:0]     win_idx;
    logic [TW-1:0]     tcnt, tcnt_nx;
    logic [LW-1:0]     lcnt, lcnt_nx;
    logic [DW-1:0]     delay_nx;
    logic              fail_nx, cnt_clr, cnt_run;

    // History and fill run every cycle regardless of FSM state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 1; k <= MAX_DELAY; k++) sreg[k] <= '0;
            fill <= '0;
        end else begin
            sreg[1] <= ref_in;
            for (int k = 2; k <= MAX_DELAY; k++) sreg[k] <= sreg[k-1];
            if (fill != DW'(MAX_DELAY)) fill <= fill + 1'b1;
        end
    end

    // A tap only counts once real samples have reached it, never reset-cleared history.
    always_comb begin
        hist[0] = ref_in;
        for (int k = 1; k <= MAX_DELAY; k++) hist[k] = sreg[k];
        hit     = '0;
        winner  = '0;
        for (int k = 0; k <= MAX_DELAY; k++) begin
            hit[k]    = (fill >= DW'(k)) && (dly_in == hist[k]);
            winner[k] = hit[k] && (cnt[k] >= CW'(MATCH_LEN - 1));
        end
        any_win = |winner;
        win_idx = '0;
        for (int k = MAX_DELAY; k >= 0; k--) begin
            if (winner[k]) win_idx = DW'(k);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k <= MAX_DELAY; k++) cnt[k] <= '0;
        end else if (cnt_clr) begin
            for (int k = 0; k <= MAX_DELAY; k++) cnt[k] <= '0;
        end else if (cnt_run) begin
            for (int k = 0; k <= MAX_DELAY; k++) begin
                if (!hit[k])                          cnt[k] <= '0;
                else if (cnt[k] != CW'(MATCH_LEN))    cnt[k] <= cnt[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            delay <= '0;
            fail  <= 1'b0;
            tcnt  <= '0;
            lcnt  <= '0;
        end else begin
            state <= state_nx;
            delay <= delay_nx;
            fail  <= fail_nx;
            tcnt  <= tcnt_nx;
            lcnt  <= lcnt_nx;
        end
    end

    // A start pulse takes precedence over every lock, loss and timeout event.
    always_comb begin
        state_nx = state;
        delay_nx = delay;
        fail_nx  = fail;
        tcnt_nx  = tcnt;
        lcnt_nx  = lcnt;
        cnt_clr  = 1'b0;
        cnt_run  = 1'b0;
        if (start) begin
            state_nx = SEARCH;
            fail_nx  = 1'b0;
            tcnt_nx  = '0;
            cnt_clr  = 1'b1;
        end else begin
            case (state)
                SEARCH: begin
                    cnt_run = 1'b1;
                    if (any_win) begin
                        state_nx = LOCKED;
                        delay_nx = win_idx;
                        lcnt_nx  = '0;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        state_nx = IDLE;
                        fail_nx  = 1'b1;
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (hit[delay]) begin
                        lcnt_nx = '0;
                    end else if (lcnt == LW'(LOSS_LEN - 1)) begin
                        state_nx = SEARCH;
                        tcnt_nx  = '0;
                        cnt_clr  = 1'b1;
                    end else begin
                        lcnt_nx = lcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (state == LOCKED);
    assign busy  = (state == SEARCH);

endmodule

// File: tb/tb_data_delay_meas.sv
// Directed bench for data_delay_meas; edge numbers count posedges since reset release.
module tb_data_delay_meas;

    logic       clk, resetn, start;
    logic [3:0] ref_in, dly_in;
    logic [2:0] delay;
    logic       valid, busy, fail;

    int         total, bad, s, d;
    bit         ref_const, dly_const;
    logic [3:0] cval;

    data_delay_meas dut (
        .clk(clk), .resetn(resetn), .start(start), .ref_in(ref_in), .dly_in(dly_in),
        .delay(delay), .valid(valid), .busy(busy), .fail(fail)
    );

    always #5 clk = ~clk;

    // Drives sample s+1, lets the edge happen, and leaves time 1 ns after it.
    task automatic applyStimulus(input logic st);
        s++;
        start  = st;
        ref_in = ref_const ? cval : 4'(s);
        dly_in = dly_const ? cval : 4'(s - d);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) applyStimulus(1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic eb,
                               input logic ef, input logic [2:0] ed);
        total++;
        assert ({valid, busy, fail, delay} === {ev, eb, ef, ed})
        else begin
            bad++;
            $error("[TB] FAIL %s: got valid=%b busy=%b fail=%b delay=%0d, want valid=%b busy=%b fail=%b delay=%0d",
                   tag, valid, busy, fail, delay, ev, eb, ef, ed);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        start  = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        s      = 0;
    endtask

    initial begin
        clk = 0; resetn = 0; start = 0; ref_in = 0; dly_in = 0;
        total = 0; bad = 0; s = 0; d = 3;
        ref_const = 0; dly_const = 0; cval = 4'h0;
        #12;
        checkOutput("reset", 0, 0, 0, 3'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Delay 3, start at edge 20, lock at edge 28
        d = 3;
        run(19);
        applyStimulus(1'b1);
        checkOutput("t1_start", 0, 1, 0, 3'd0);
        run(7);
        checkOutput("t1_busy", 0, 1, 0, 3'd0);
        run(1);
        checkOutput("t1_lock", 1, 0, 0, 3'd3);

        // Switch to delay 5 at edge 31: drop at 34, relock at 42
        run(2);
        d = 5;
        run(3);
        checkOutput("t3_hold", 1, 0, 0, 3'd3);
        run(1);
        checkOutput("t3_drop", 0, 1, 0, 3'd3);
        run(7);
        checkOutput("t3_search", 0, 1, 0, 3'd3);
        run(1);
        checkOutput("t3_relock", 1, 0, 0, 3'd5);

        // Constant 4'hA: start at edge 44, fail at edge 108, delay keeps 5
        dly_const = 1; cval = 4'hA;
        run(1);
        applyStimulus(1'b1);
        checkOutput("t4_start", 0, 1, 0, 3'd5);
        run(63);
        checkOutput("t4_pre", 0, 1, 0, 3'd5);
        run(1);
        checkOutput("t4_fail", 0, 0, 1, 3'd5);
        run(2);
        checkOutput("t4_sticky", 0, 0, 1, 3'd5);
        applyStimulus(1'b1);
        checkOutput("t4_clear", 0, 1, 0, 3'd5);

        // Delay 0, start at edge 1, lock at edge 9
        doReset();
        dly_const = 0; d = 0;
        applyStimulus(1'b1);
        checkOutput("t2a_start", 0, 1, 0, 3'd0);
        run(7);
        checkOutput("t2a_busy", 0, 1, 0, 3'd0);
        run(1);
        checkOutput("t2a_lock", 1, 0, 0, 3'd0);

        // Delay 7, start at edge 1, tap 7 eligible from edge 8, lock at edge 15
        doReset();
        d = 7;
        applyStimulus(1'b1);
        run(13);
        checkOutput("t2b_busy", 0, 1, 0, 3'd0);
        run(1);
        checkOutput("t2b_lock", 1, 0, 0, 3'd7);
        run(4);
        checkOutput("t2b_hold", 1, 0, 0, 3'd7);

        // Both streams constant 5: every tap matches, tap 0 wins at edge 18
        doReset();
        ref_const = 1; dly_const = 1; cval = 4'h5;
        run(9);
        applyStimulus(1'b1);
        run(7);
        checkOutput("t5_busy", 0, 1, 0, 3'd0);
        run(1);
        checkOutput("t5_lock", 1, 0, 0, 3'd0);

        // Reset mid-search, then relock only after history refills (edge 11)
        doReset();
        ref_const = 0; dly_const = 0; d = 3;
        applyStimulus(1'b1);
        run(3);
        checkOutput("t6_pre", 0, 1, 0, 3'd0);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("t6_async", 0, 0, 0, 3'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        s = 0;
        applyStimulus(1'b1);
        run(9);
        checkOutput("t6_busy", 0, 1, 0, 3'd0);
        run(1);
        checkOutput("t6_lock", 1, 0, 0, 3'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
